ecc_20_enc_fault_detc: RTL
==========================

Name: ecc_20_enc_fault_detc

Overview:
- Write-side SECDED encoder for 20-bit FIFO/RAM words.
- Produces 6 check bits that round-trip with the team's 20-bit SECDED decoder/fault-detect block.
- Encoder logic is duplicated and the two results are compared each accepted word; a mismatch flags an encoder fault.
- One registered, valid/ready-handshaked output stage sits between the write requester and the storage array.

Parameters:
- DATA_WIDTH, 20, data word width; fixed by the parity mapping below.
- PARITY_WIDTH, 6, check bits: 5 Hamming + 1 overall.
- CNT_WIDTH, 8, width of the saturating fault counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- ecc_fault_detc_en  input  1  enables the dual-encoder compare.
- bypass  input  1  1 = pass data with parity forced to 0, no compare.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- data_in  input  DATA_WIDTH  word to encode.
- out_valid  output  1  registered word valid.
- out_ready  input  1  downstream accepts.
- data_out  output  DATA_WIDTH  registered data.
- parity_out  output  PARITY_WIDTH  registered check bits.
- ecc_fault  output  1  registered with the word: encoder mismatch on this word.
- fault_sticky  output  1  set on any fault, held until fault_clr.
- fault_clr  input  1  clears fault_sticky and fault_cnt.
- fault_cnt  output  CNT_WIDTH  saturating count of faulted words.

Behaviour:
- Parity mapping: Hamming positions 1..25; check bits at positions 1,2,4,8,16.
- data_in[0..19] occupy non-power positions 3,5,6,7,9..15,17..25 in ascending order.
- parity[i], i=0..4, is the XOR of the data bits whose position has bit i set.
- parity[5] is the XOR of data[19:0] and parity[4:0]; this gives even overall parity.
- Handshake: in_ready = ~out_valid | out_ready, purely combinational.
- Accept occurs when in_valid & in_ready. The output register then loads on the same edge, and out_valid=1 the next cycle. Latency is 1 cycle.
- out_valid drops when out_ready=1 and no new word is accepted.
- Output register contents are stable while out_valid & ~out_ready.
- Simultaneous output consume and input accept yields full throughput: one word per cycle, no bubble.
- Compare: both encoder copies compute parity from data_in. mismatch = (p0 != p1) & ecc_fault_detc_en & ~bypass.
- On mismatch, parity_out loads the copy-0 result and ecc_fault=1 travels with the word.
- bypass=1: parity_out loads 0, ecc_fault=0, data passes unchanged.
- fault_sticky is set on the accept edge of a mismatched word.
- fault_cnt increments on the accept edge of a mismatched word and saturates at 2^CNT_WIDTH-1.
- fault_clr has priority over a same-cycle increment. Both fault_sticky and fault_cnt end at 0; that faulted word is not counted, though its ecc_fault is still 1.
- Reset: out_valid=0, data_out=0, parity_out=0, ecc_fault=0, fault_sticky=0, fault_cnt=0. in_ready=1 in the first cycle after reset.
- Reset mid-transfer discards the held word with no output; injection arm flags are cleared.
- ecc_fault_detc_en and bypass are sampled only at accept.

Optional Feature:
- Macro: ECC_20_ENC_ERR_INJ_EN.
- Defined: adds inputs err_inj_sbit and err_inj_dbit, 1 bit each. A high pulse arms a one-shot flag.
- The next accepted non-bypass word is stored with data_out[0] flipped (sbit), or data_out[1:0] flipped (dbit). Parity is computed on the unflipped data.
- dbit has priority if both are armed. The arm clears on that accept.
- An arm pulse in the same cycle as an accept applies to that word.
- ecc_fault is not asserted by injection.
- Undefined: ports absent, no injection logic, data_out always equals the accepted data.

Test Plan:
- Reset, then accept data_in=20'h00001 -> next cycle out_valid=1, data_out=20'h00001, parity_out=6'h23. Feeding this word to the team's 20-bit decoder gives no errors.
- Accept data_in=20'hFFFFF and 20'hA5A5A with out_ready=1 continuously -> two words on consecutive cycles. Each word's parity matches the mapping, and the decoder shows sbit_err=dbit_err=0.
- Hold out_ready=0 with a word held -> in_ready=0, and data_out/parity_out stable for 10 cycles. Raise out_ready -> the word drains, and a new word enters the same cycle.
- Force copy-1 parity bit 2 flipped, ecc_fault_detc_en=1 -> ecc_fault=1 with the word, fault_sticky=1, fault_cnt=1. Repeat with en=0 -> no flag, fault_cnt stays 1.
- Apply 260 faulted words -> fault_cnt=255. Pulse fault_clr during a faulted accept -> fault_cnt=0, fault_sticky=0.
- With ECC_20_ENC_ERR_INJ_EN defined: arm sbit, send 20'h00000 -> data_out=20'h00001, parity_out=0, decoder reports sbit_err. Arm dbit -> data_out=20'h00003, decoder reports dbit_err. The following word is clean.

Source files
------------

// File: rtl/ecc_20_enc_fault_detc.sv
// ecc_20_enc_fault_detc: write-side SECDED encoder for 20-bit storage words.
// Two copies of the encoder run on every word, and their results are compared
// when the word is accepted. A mismatch travels with the word as ecc_fault and
// is also recorded in a sticky flag and a saturating counter. One registered
// valid/ready output stage sits between the requester and the array.
// Optional feature macro: ECC_20_ENC_ERR_INJ_EN adds one-shot single-bit and
// double-bit data error injection for exercising the downstream decoder.
//
// Handshake: a word moves across an interface on a rising edge where valid and
// ready are both high. valid must not depend on ready. in_ready is
// ~out_valid | out_ready, so a held word can drain on the same edge that
// loads the next one.
module ecc_20_enc_fault_detc #(
    parameter int DATA_WIDTH   = 20,
    parameter int PARITY_WIDTH = 6,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    input  logic                    fault_clr,
    output logic [CNT_WIDTH-1:0]    fault_cnt
`ifdef ECC_20_ENC_ERR_INJ_EN
    ,
    input  logic                    err_inj_sbit,
    input  logic                    err_inj_dbit
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Hamming code over positions 1..25. Check bits sit at the power-of-two
    // positions, and data fills the remaining positions in ascending order.
    // The top bit gives even parity over the whole codeword.
    function automatic logic [PARITY_WIDTH-1:0] enc_parity(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        int k;
        p = '0;
        k = 0;
        for (int pos = 1; pos <= DATA_WIDTH + PARITY_WIDTH - 1; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < PARITY_WIDTH - 1; i++) begin
                    if (pos[i]) p[i] = p[i] ^ d[k];
                end
                k = k + 1;
            end
        end
        p[PARITY_WIDTH-1] = (^d) ^ (^p[PARITY_WIDTH-2:0]);
        return p;
    endfunction

    logic [PARITY_WIDTH-1:0] parity_0;
    logic [PARITY_WIDTH-1:0] parity_1;
    logic                    accept;
    logic                    mismatch;
    logic                    fault_hit;
    logic [DATA_WIDTH-1:0]   inj_mask;

    // Both copies must survive synthesis as separate cones for the compare to
    // mean anything; keep them apart (e.g. with keep/dont_touch) in the flow.
    assign parity_0  = enc_parity(data_in);
    assign parity_1  = enc_parity(data_in);

    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign mismatch  = (parity_0 != parity_1) & ecc_fault_detc_en & ~bypass;
    assign fault_hit = accept & mismatch;

`ifdef ECC_20_ENC_ERR_INJ_EN
    logic arm_sbit;
    logic arm_dbit;
    logic eff_sbit;
    logic eff_dbit;

    // A pulse arriving on the accept edge counts as already armed.
    assign eff_sbit = arm_sbit | err_inj_sbit;
    assign eff_dbit = arm_dbit | err_inj_dbit;

    // Select the flip pattern for the next non-bypass word; dbit wins over sbit.
    always_comb begin
        inj_mask = '0;
        if (!bypass) begin
            if (eff_dbit)      inj_mask[1:0] = 2'b11;
            else if (eff_sbit) inj_mask[0]   = 1'b1;
        end
    end

    // Arm flags hold until a non-bypass word consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_sbit <= 1'b0;
            arm_dbit <= 1'b0;
        end else if (accept && !bypass) begin
            arm_sbit <= 1'b0;
            arm_dbit <= 1'b0;
        end else begin
            if (err_inj_sbit) arm_sbit <= 1'b1;
            if (err_inj_dbit) arm_dbit <= 1'b1;
        end
    end
`else
    assign inj_mask = '0;
`endif

    // Output stage: load on accept, otherwise drain when downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            parity_out <= '0;
            ecc_fault  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            data_out   <= data_in ^ inj_mask;
            parity_out <= bypass ? '0 : parity_0;
            ecc_fault  <= mismatch;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Fault bookkeeping; a clear wins over a same-edge faulted accept.
    always_ff @(posedge clk) begin
        if (rst || fault_clr) begin
            fault_sticky <= 1'b0;
            fault_cnt    <= '0;
        end else if (fault_hit) begin
            fault_sticky <= 1'b1;
            if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + 1'b1;
        end
    end

endmodule
